// File: rtl/exu_mul_core.sv
// rtl/exu_mul_core.sv - iterative 32x32 multiplier (MUL/MULH/MULHSU/MULHU), CHUNK_W multiplier bits per cycle
module exu_mul_core #(
    parameter int CHUNK_W = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mul_start_i,
    input  logic [31:0] mul_multiplicand_i,
    input  logic [31:0] mul_multiplier_i,
    input  logic [3:0]  mul_op_i,
    output logic [31:0] mul_result_o,
    output logic        mul_busy_o,
    output logic        mul_valid_o
);

    localparam int REG_DATA_WIDTH = 32;
    localparam int NITER          = REG_DATA_WIDTH / CHUNK_W;
    localparam int CNT_W          = 6;

    typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

    state_t             state, state_nxt;
    logic [31:0]        a_mag_q, b_mag_q;
    logic [63:0]        acc_q;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_q;
    logic               low_q;
    logic [31:0]        result_q;

    logic               op_mul, op_mulh, op_mulhsu;
    logic               a_neg, b_neg;
    logic [31:0]        a_mag, b_mag;
    logic               last_iter;
    logic [5:0]         shamt;
    logic [CHUNK_W-1:0] b_chunk;
    logic [63:0]        addend;
    logic [63:0]        product;

    // Lowest set bit wins; an all-zero op falls back to MUL.
    always_comb begin
        op_mul    = mul_op_i[0] | (mul_op_i == 4'b0000);
        op_mulh   = ~mul_op_i[0] & mul_op_i[1];
        op_mulhsu = (mul_op_i[1:0] == 2'b00) & mul_op_i[2];
        a_neg     = mul_multiplicand_i[31] & (op_mulh | op_mulhsu);
        b_neg     = mul_multiplier_i[31] & op_mulh;
        // -0x80000000 wraps back to 0x80000000, which is the correct unsigned magnitude
        a_mag     = a_neg ? (32'd0 - mul_multiplicand_i) : mul_multiplicand_i;
        b_mag     = b_neg ? (32'd0 - mul_multiplier_i) : mul_multiplier_i;
    end

    always_comb begin
        last_iter = (cnt_q == CNT_W'(NITER - 1));
        shamt     = 6'(int'(cnt_q) * CHUNK_W);
        b_chunk   = CHUNK_W'(b_mag_q >> shamt);
        addend    = ({32'd0, a_mag_q} * {{(64 - CHUNK_W){1'b0}}, b_chunk}) << shamt;
        product   = neg_q ? (64'd0 - acc_q) : acc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (mul_start_i) state_nxt = CALC;
            CALC:    if (last_iter)   state_nxt = SIGN;
            SIGN:    state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_mag_q  <= '0;
            b_mag_q  <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            neg_q    <= 1'b0;
            low_q    <= 1'b0;
            result_q <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (mul_start_i) begin
                        a_mag_q <= a_mag;
                        b_mag_q <= b_mag;
                        low_q   <= op_mul;
                        neg_q   <= a_neg ^ b_neg;
                        acc_q   <= '0;
                        cnt_q   <= '0;
                    end
                end
                CALC: begin
                    acc_q <= acc_q + addend;
                    cnt_q <= cnt_q + 1'b1;
                end
                SIGN: begin
                    result_q <= low_q ? product[31:0] : product[63:32];
                end
                default: ;
            endcase
        end
    end

    assign mul_result_o = result_q;
    assign mul_busy_o   = (state != IDLE);
    assign mul_valid_o  = (state == DONE);

endmodule

// File: tb/tb_exu_mul_core.sv
// tb/tb_exu_mul_core.sv - directed bench for exu_mul_core at CHUNK_W 8, 1 and 32
module tb_exu_mul_core;

    localparam logic [3:0] OP_MUL    = 4'b0001;
    localparam logic [3:0] OP_MULH   = 4'b0010;
    localparam logic [3:0] OP_MULHSU = 4'b0100;
    localparam logic [3:0] OP_MULHU  = 4'b1000;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [3:0]  op;
    logic [2:0]  busy_w;
    logic [2:0]  valid_w;
    logic [31:0] res_w [3];

    int errors = 0;
    int checks = 0;
    int lat_exp [3] = '{6, 34, 3};

    exu_mul_core #(.CHUNK_W(8)) dut8 (
        .clk(clk), .rst_n(rst_n), .mul_start_i(start),
        .mul_multiplicand_i(op_a), .mul_multiplier_i(op_b), .mul_op_i(op),
        .mul_result_o(res_w[0]), .mul_busy_o(busy_w[0]), .mul_valid_o(valid_w[0])
    );

    exu_mul_core #(.CHUNK_W(1)) dut1 (
        .clk(clk), .rst_n(rst_n), .mul_start_i(start),
        .mul_multiplicand_i(op_a), .mul_multiplier_i(op_b), .mul_op_i(op),
        .mul_result_o(res_w[1]), .mul_busy_o(busy_w[1]), .mul_valid_o(valid_w[1])
    );

    exu_mul_core #(.CHUNK_W(32)) dut32 (
        .clk(clk), .rst_n(rst_n), .mul_start_i(start),
        .mul_multiplicand_i(op_a), .mul_multiplier_i(op_b), .mul_op_i(op),
        .mul_result_o(res_w[2]), .mul_busy_o(busy_w[2]), .mul_valid_o(valid_w[2])
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic wait_idle();
        int k;
        k = 0;
        while (busy_w !== 3'b000 && k < 60) begin
            @(negedge clk);
            k++;
        end
        checks++;
        if (busy_w !== 3'b000) begin
            errors++;
            $display("FAIL wait_idle: busy=%b required 000", busy_w);
        end
    endtask

    // Issue one op to all three instances and check result and valid cycle of each.
    task automatic run_vec(input string name, input logic [3:0] vop,
                           input logic [31:0] va, input logic [31:0] vb,
                           input logic [31:0] exp);
        int          first [3];
        int          pulses [3];
        logic [31:0] got [3];
        wait_idle();
        for (int d = 0; d < 3; d++) begin
            first[d]  = -1;
            pulses[d] = 0;
            got[d]    = '0;
        end
        @(negedge clk);
        start = 1'b1; op = vop; op_a = va; op_b = vb;
        for (int n = 1; n <= 36; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
                op_a  = ~va;
                op_b  = ~vb;
            end
            for (int d = 0; d < 3; d++) begin
                if (valid_w[d] === 1'b1) begin
                    pulses[d]++;
                    if (first[d] < 0) begin
                        first[d] = n;
                        got[d]   = res_w[d];
                    end
                end
            end
        end
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (first[d] != lat_exp[d]) begin
                errors++;
                $display("FAIL %s lat[%0d]: valid at T+%0d required T+%0d", name, d, first[d], lat_exp[d]);
            end
            checks++;
            if (got[d] !== exp) begin
                errors++;
                $display("FAIL %s result[%0d]: got %h required %h", name, d, got[d], exp);
            end
            checks++;
            if (pulses[d] != 1) begin
                errors++;
                $display("FAIL %s pulses[%0d]: got %0d required 1", name, d, pulses[d]);
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; op = OP_MUL; op_a = '0; op_b = '0;
        repeat (2) @(negedge clk);
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (busy_w[d] !== 1'b0 || valid_w[d] !== 1'b0 || res_w[d] !== 32'h0) begin
                errors++;
                $display("FAIL reset[%0d]: busy=%b valid=%b result=%h required 0 0 0",
                         d, busy_w[d], valid_w[d], res_w[d]);
            end
        end
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy_w !== 3'b000 || valid_w !== 3'b000) begin
            errors++;
            $display("FAIL reset_release: busy=%b valid=%b required 000 000", busy_w, valid_w);
        end
    endtask

    task automatic test_mul_basic();
        @(negedge clk);
        start = 1'b1; op = OP_MUL; op_a = 32'd7; op_b = 32'd6;
        for (int n = 1; n <= 7; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            checks++;
            if (busy_w[0] !== (n <= 6)) begin
                errors++;
                $display("FAIL basic_busy T+%0d: got %b required %b", n, busy_w[0], (n <= 6));
            end
            checks++;
            if (valid_w[0] !== (n == 6)) begin
                errors++;
                $display("FAIL basic_valid T+%0d: got %b required %b", n, valid_w[0], (n == 6));
            end
            if (n == 6) begin
                checks++;
                if (res_w[0] !== 32'h0000002A) begin
                    errors++;
                    $display("FAIL basic_result: got %h required 0000002a", res_w[0]);
                end
            end
        end
    endtask

    task automatic test_ffff_all_chunks();
        run_vec("ffff_mul",    OP_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
        run_vec("ffff_mulh",   OP_MULH,   32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_vec("ffff_mulhsu", OP_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_vec("ffff_mulhu",  OP_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
    endtask

    task automatic test_overflow_edges();
        run_vec("mulh_min_min",   OP_MULH,   32'h80000000, 32'h80000000, 32'h40000000);
        run_vec("mulhsu_min_two", OP_MULHSU, 32'h80000000, 32'h00000002, 32'hFFFFFFFF);
        run_vec("mulh_max_min",   OP_MULH,   32'h7FFFFFFF, 32'h80000000, 32'hC0000000);
        run_vec("mul_max_min",    OP_MUL,    32'h7FFFFFFF, 32'h80000000, 32'h80000000);
    endtask

    task automatic test_signed_mix();
        run_vec("mul_m3_5",    OP_MUL,    32'hFFFFFFFD, 32'd5, 32'hFFFFFFF1);
        run_vec("mulh_m3_5",   OP_MULH,   32'hFFFFFFFD, 32'd5, 32'hFFFFFFFF);
        run_vec("mulhu_m3_5",  OP_MULHU,  32'hFFFFFFFD, 32'd5, 32'h00000004);
        run_vec("mulhsu_5_m3", OP_MULHSU, 32'd5, 32'hFFFFFFFD, 32'h00000004);
        run_vec("mulhu_chunk", OP_MULHU,  32'h12345678, 32'h00000010, 32'h00000001);
        run_vec("mul_chunk",   OP_MUL,    32'h12345678, 32'h00000010, 32'h23456780);
        run_vec("mul_2p32",    OP_MUL,    32'h00010000, 32'h00010000, 32'h00000000);
    endtask

    task automatic test_op_decode();
        run_vec("op_zero_mul",  4'b0000, 32'd7, 32'd6, 32'h0000002A);
        run_vec("op_0110_mulh", 4'b0110, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
        run_vec("op_1100_hsu",  4'b1100, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);
        run_vec("op_1111_mul",  4'b1111, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001);
    endtask

    task automatic test_back_to_back();
        logic exp_v;
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = OP_MUL; op_a = 32'd7; op_b = 32'd6;
        for (int n = 1; n <= 14; n++) begin
            @(negedge clk);
            if (n == 1) begin
                start = 1'b0;
            end else if (n <= 7) begin
                start = 1'b1; op_a = 32'd3; op_b = 32'd5;
            end else begin
                start = 1'b0;
            end
            if (n == 7) begin
                checks++;
                if (busy_w[0] !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_busy T+7: got %b required 0", busy_w[0]);
                end
            end
            exp_v = (n == 6) || (n == 13);
            checks++;
            if (valid_w[0] !== exp_v) begin
                errors++;
                $display("FAIL b2b_valid T+%0d: got %b required %b", n, valid_w[0], exp_v);
            end
            if (n == 6 || n == 13) begin
                checks++;
                if (res_w[0] !== ((n == 6) ? 32'h2A : 32'hF)) begin
                    errors++;
                    $display("FAIL b2b_result T+%0d: got %h required %h", n, res_w[0],
                             ((n == 6) ? 32'h2A : 32'hF));
                end
            end
        end
    endtask

    task automatic test_reset_abort();
        int pulses;
        pulses = 0;
        wait_idle();
        @(negedge clk);
        start = 1'b1; op = OP_MUL; op_a = 32'd7; op_b = 32'd6;
        for (int n = 1; n <= 8; n++) begin
            @(negedge clk);
            if (n == 1) start = 1'b0;
            if (n == 3) begin
                rst_n = 1'b0;
                #1;
                checks++;
                if (busy_w !== 3'b000) begin
                    errors++;
                    $display("FAIL abort_busy: got %b required 000", busy_w);
                end
            end
            if (n == 4) begin
                checks++;
                if (res_w[0] !== 32'h0) begin
                    errors++;
                    $display("FAIL abort_result: got %h required 00000000", res_w[0]);
                end
                rst_n = 1'b1;
            end
            if (valid_w !== 3'b000) pulses++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL abort_valid: %0d valid cycles required 0", pulses);
        end
        run_vec("abort_restart", OP_MUL, 32'd3, 32'd5, 32'h0000000F);
    endtask

    initial begin
        test_reset();
        test_mul_basic();
        test_ffff_all_chunks();
        test_overflow_edges();
        test_signed_mix();
        test_op_decode();
        test_back_to_back();
        test_reset_abort();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
